// File: rtl/ps_mul_dec_pkg.sv
// Shared encodings for the multiplier compute-field decoder: field positions,
// class/subclass codes and the list of reserved dtsts patterns.
package ps_mul_dec_pkg;

    localparam int OPC_W     = 10;
    localparam int CLS_HI    = 9;
    localparam int CLS_LO    = 8;
    localparam int OTREG_BIT = 7;
    localparam int SC_HI     = 6;
    localparam int SC_LO     = 5;
    localparam int DTSTS_HI  = 4;
    localparam int DTSTS_LO  = 1;
    localparam int RSVD_BIT  = 0;

    typedef enum logic [1:0] {
        CLS_SAT_XFER = 2'b00,
        CLS_PRODUCT  = 2'b01,
        CLS_MAC_ADD  = 2'b10,
        CLS_MAC_SUB  = 2'b11
    } mul_cls_e;

    typedef enum logic [1:0] {
        SC_MR0    = 2'b00,
        SC_MR1    = 2'b01,
        SC_MR2    = 2'b10,
        SC_SAT_MR = 2'b11
    } mul_sc_e;

    // Issued control word; dtsts is {ryUbS, rxUbS, IbF, rnd}.
    typedef struct packed {
        mul_cls_e   cls;
        logic       otreg;
        mul_sc_e    sc;
        logic [3:0] dtsts;
    } mul_ctl_t;

    localparam int N_ILL_DTSTS = 4;
    localparam logic [4*N_ILL_DTSTS-1:0] ILL_DTSTS = {4'b1101, 4'b1001, 4'b0101, 4'b0001};

    function automatic logic dtsts_illegal(input logic [3:0] dtsts);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_ILL_DTSTS; i++) begin
            if (dtsts == ILL_DTSTS[i*4 +: 4]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Takes the opcode without its reserved bit; indices keep their field positions.
    function automatic mul_ctl_t opc_fields(input logic [OPC_W-1:DTSTS_LO] opc);
        mul_ctl_t f;
        f.cls   = mul_cls_e'(opc[CLS_HI:CLS_LO]);
        f.otreg = opc[OTREG_BIT];
        f.sc    = mul_sc_e'(opc[SC_HI:SC_LO]);
        f.dtsts = opc[DTSTS_HI:DTSTS_LO];
        return f;
    endfunction

endpackage

// File: rtl/ps_mul_opc_chk.sv
// Combinational legality check of the multiplier compute field.
import ps_mul_dec_pkg::*;

module ps_mul_opc_chk (
    input  logic [OPC_W-1:0] mul_opc,
    output logic             legal
);

    mul_ctl_t f;
    logic     ill_rsvd;
    logic     ill_dtsts;
    logic     ill_sat;
    logic     ill_subcls;

    always_comb begin
        f          = opc_fields(mul_opc[OPC_W-1:DTSTS_LO]);
        ill_rsvd   = mul_opc[RSVD_BIT];
        ill_dtsts  = dtsts_illegal(f.dtsts);
        // SAT only exists as an MR-targeted operation.
        ill_sat    = (f.cls == CLS_SAT_XFER) && (f.sc == SC_SAT_MR) && !f.otreg;
        ill_subcls = (f.cls != CLS_SAT_XFER) && (f.sc != SC_MR0);
        legal      = !(ill_rsvd || ill_dtsts || ill_sat || ill_subcls);
    end

endmodule

// File: rtl/ps_mul_dec.sv
// Multiplier compute-field decoder: issues a registered control word and
// captures the multiplier status flags two cycles after issue.
import ps_mul_dec_pkg::*;

module ps_mul_dec #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_vld,
    input  logic [OPC_W-1:0] mul_opc,
    input  logic             cond_pass,
    input  logic             stall,
    input  logic             stky_clr,
    input  logic             mul_ps_mv,
    input  logic             mul_ps_mn,
    output logic             ps_mul_en,
    output logic             ps_mul_otreg,
    output logic [3:0]       ps_mul_dtsts,
    output logic [1:0]       ps_mul_cls,
    output logic [1:0]       ps_mul_sc,
    output logic             illegal_opc,
    output logic             astat_mv,
    output logic             astat_mn,
    output logic             stky_mvs,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic             opc_legal;
    logic             issue_req;
    logic             accept;
    logic             reject;
    logic             exe_vld;
    logic             ovf_capture;
    logic             cnt_full;
    logic             stky_d;
    logic [CNT_W-1:0] ovf_cnt_d;
    mul_ctl_t         ctl_d;
    mul_ctl_t         ctl_q;

    ps_mul_opc_chk u_chk (
        .mul_opc (mul_opc),
        .legal   (opc_legal)
    );

    // instr_vld is the valid, ~stall the ready; a field transfers only when
    // valid & ready & cond_pass, and the decision lands one cycle later.
    always_comb begin
        issue_req = instr_vld & ~stall & cond_pass;
        accept    = issue_req & opc_legal;
        reject    = issue_req & ~opc_legal;
        ctl_d     = accept ? opc_fields(mul_opc[OPC_W-1:DTSTS_LO]) : ctl_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_mul_en   <= 1'b0;
            illegal_opc <= 1'b0;
            exe_vld     <= 1'b0;
            ctl_q       <= '0;
        end else begin
            ps_mul_en   <= accept;
            illegal_opc <= reject;
            exe_vld     <= ps_mul_en;
            ctl_q       <= ctl_d;
        end
    end

    assign ps_mul_cls   = ctl_q.cls;
    assign ps_mul_otreg = ctl_q.otreg;
    assign ps_mul_sc    = ctl_q.sc;
    assign ps_mul_dtsts = ctl_q.dtsts;

    // A capture coinciding with a clear leaves the new event recorded.
    always_comb begin
        ovf_capture = exe_vld & mul_ps_mv;
        cnt_full    = &ovf_cnt;
        stky_d      = ovf_capture | (stky_mvs & ~stky_clr);
        ovf_cnt_d   = ovf_cnt;
        if (stky_clr) begin
            ovf_cnt_d = ovf_capture ? CNT_W'(1) : '0;
        end else if (ovf_capture && !cnt_full) begin
            ovf_cnt_d = ovf_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            astat_mv <= 1'b0;
            astat_mn <= 1'b0;
            stky_mvs <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (exe_vld) begin
                astat_mv <= mul_ps_mv;
                astat_mn <= mul_ps_mn;
            end
            stky_mvs <= stky_d;
            ovf_cnt  <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_ps_mul_dec.sv
// Self-checking bench for ps_mul_dec: issue/decode, legality, stall, flag
// capture, counter saturation and reset during execute.
`timescale 1ns/1ps

module tb_ps_mul_dec;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             instr_vld = 1'b0;
    logic [9:0]       mul_opc = '0;
    logic             cond_pass = 1'b0;
    logic             stall = 1'b0;
    logic             stky_clr = 1'b0;
    logic             mul_ps_mv = 1'b0;
    logic             mul_ps_mn = 1'b0;
    logic             ps_mul_en;
    logic             ps_mul_otreg;
    logic [3:0]       ps_mul_dtsts;
    logic [1:0]       ps_mul_cls;
    logic [1:0]       ps_mul_sc;
    logic             illegal_opc;
    logic             astat_mv;
    logic             astat_mn;
    logic             stky_mvs;
    logic [CNT_W-1:0] ovf_cnt;

    int checks   = 0;
    int failures = 0;

    // Expected issued words {cls, otreg, sc, dtsts}
    logic [8:0] exp_q[$];

    logic       m_e1, m_e2, m_ill, m_mv, m_mn, m_stky;
    logic [7:0] m_cnt;
    logic [8:0] m_fld;

    ps_mul_dec #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_vld    (instr_vld),
        .mul_opc      (mul_opc),
        .cond_pass    (cond_pass),
        .stall        (stall),
        .stky_clr     (stky_clr),
        .mul_ps_mv    (mul_ps_mv),
        .mul_ps_mn    (mul_ps_mn),
        .ps_mul_en    (ps_mul_en),
        .ps_mul_otreg (ps_mul_otreg),
        .ps_mul_dtsts (ps_mul_dtsts),
        .ps_mul_cls   (ps_mul_cls),
        .ps_mul_sc    (ps_mul_sc),
        .illegal_opc  (illegal_opc),
        .astat_mv     (astat_mv),
        .astat_mn     (astat_mn),
        .stky_mvs     (stky_mvs),
        .ovf_cnt      (ovf_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_e1 = 0; m_e2 = 0; m_ill = 0; m_mv = 0; m_mn = 0; m_stky = 0;
        m_cnt = '0; m_fld = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        instr_vld = 0; mul_opc = '0; cond_pass = 0; stall = 0;
        stky_clr = 0; mul_ps_mv = 0; mul_ps_mn = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic tb_legal(input logic [9:0] o);
        logic [1:0] cls;
        logic [1:0] sc;
        logic       ot;
        logic [3:0] dt;
        logic       ok;
        cls = o[9:8]; ot = o[7]; sc = o[6:5]; dt = o[4:1];
        ok = 1'b1;
        if (o[0]) ok = 1'b0;
        case (dt)
            4'b0001, 4'b0101, 4'b1001, 4'b1101: ok = 1'b0;
            default: ;
        endcase
        if (cls == 2'b00 && sc == 2'b11 && !ot) ok = 1'b0;
        if (cls != 2'b00 && sc != 2'b00) ok = 1'b0;
        return ok;
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of inputs, advances the model, then waits past the edge.
    task automatic step(input logic vld, input logic [9:0] opc, input logic cp,
                        input logic st, input logic clr, input logic mv, input logic mn);
        logic iss, acc, cap;
        instr_vld = vld; mul_opc = opc; cond_pass = cp; stall = st;
        stky_clr = clr; mul_ps_mv = mv; mul_ps_mn = mn;
        iss = vld & cp & ~st;
        acc = iss & tb_legal(opc);
        cap = m_e2 & mv;
        if (m_e2) begin
            m_mv = mv;
            m_mn = mn;
        end
        if (clr) m_stky = 0;
        if (cap) m_stky = 1;
        if (clr) m_cnt = cap ? 8'd1 : 8'd0;
        else if (cap && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_e2  = m_e1;
        m_e1  = acc;
        m_ill = iss & ~acc;
        if (acc) begin
            m_fld = {opc[9:8], opc[7], opc[6:5], opc[4:1]};
            exp_q.push_back(m_fld);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic clr, input logic mv, input logic mn);
        step(1'b0, 10'b0, 1'b0, 1'b0, clr, mv, mn);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset = 1;
        #3;
        checks++;
        if ({ps_mul_en, illegal_opc} !== 2'b00) begin
            failures++;
            $display("FAIL reset_en_ill got=%b exp=00", {ps_mul_en, illegal_opc});
        end
        checks++;
        if ({ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== 9'h000) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=000", {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts});
        end
        checks++;
        if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== 11'h000) begin
            failures++;
            $display("FAIL reset_flags got=%h exp=000", {astat_mv, astat_mn, stky_mvs, ovf_cnt});
        end
        do_reset();
        idle(0, 0, 0);
        checks++;
        if (ps_mul_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_en got=%b exp=0", ps_mul_en);
        end
    endtask

    task automatic test_issue();
        logic [8:0] got;
        logic [8:0] exp_w;
        do_reset();
        step(1, 10'b01_1_00_1110_0, 1, 0, 0, 0, 0);
        got = {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts};
        checks++;
        if (ps_mul_en !== 1'b1 || illegal_opc !== 1'b0) begin
            failures++;
            $display("FAIL issue_en got en=%b ill=%b exp en=1 ill=0", ps_mul_en, illegal_opc);
        end
        checks++;
        if (got !== {2'b01, 1'b1, 2'b00, 4'b1110}) begin
            failures++;
            $display("FAIL issue_fields got=%b exp=%b", got, {2'b01, 1'b1, 2'b00, 4'b1110});
        end
        checks++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL issue_sb got=%h exp=%h", got, exp_w);
        end
        idle(0, 0, 0);
        checks++;
        if (ps_mul_en !== 1'b0 || {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== exp_w) begin
            failures++;
            $display("FAIL issue_hold got en=%b f=%h exp en=0 f=%h", ps_mul_en,
                     {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts}, exp_w);
        end
    endtask

    task automatic test_illegal();
        logic [9:0] tab [8];
        logic [8:0] got;
        logic [8:0] exp_w;
        tab = '{10'b01_1_00_0001_0, 10'b01_0_00_0101_0, 10'b00_0_00_1001_0, 10'b10_1_00_1101_0,
                10'b01_1_00_1110_1, 10'b00_0_11_0000_0, 10'b01_1_01_0000_0, 10'b11_0_10_0010_0};
        do_reset();
        step(1, 10'b00_0_01_0010_0, 1, 0, 0, 0, 0);
        got = {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts};
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if (ps_mul_en !== 1'b1 || got !== exp_w) begin
            failures++;
            $display("FAIL legal_xfer got en=%b f=%h exp en=1 f=%h", ps_mul_en, got, exp_w);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, tab[i], 1, 0, 0, 0, 0);
            checks++;
            if (illegal_opc !== 1'b1 || ps_mul_en !== 1'b0) begin
                failures++;
                $display("FAIL illegal_%0d got ill=%b en=%b exp ill=1 en=0", i, illegal_opc, ps_mul_en);
            end
            idle(0, 0, 0);
            checks++;
            if (illegal_opc !== 1'b0 || ps_mul_en !== 1'b0) begin
                failures++;
                $display("FAIL illegal_pulse_%0d got ill=%b en=%b exp ill=0 en=0", i, illegal_opc, ps_mul_en);
            end
        end
        checks++;
        if ({ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== exp_w) begin
            failures++;
            $display("FAIL illegal_hold got=%h exp=%h", {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts}, exp_w);
        end
        step(1, tab[0], 0, 0, 0, 0, 0);
        checks++;
        if (illegal_opc !== 1'b0) begin
            failures++;
            $display("FAIL illegal_condfalse got=%b exp=0", illegal_opc);
        end
        step(1, tab[0], 1, 1, 0, 0, 0);
        checks++;
        if (illegal_opc !== 1'b0) begin
            failures++;
            $display("FAIL illegal_stalled got=%b exp=0", illegal_opc);
        end
        step(1, 10'b00_1_11_0000_0, 1, 0, 0, 0, 0);
        got = {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts};
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if (ps_mul_en !== 1'b1 || illegal_opc !== 1'b0 || got !== exp_w) begin
            failures++;
            $display("FAIL legal_sat_mr got en=%b ill=%b f=%h exp en=1 ill=0 f=%h", ps_mul_en, illegal_opc, got, exp_w);
        end
        idle(0, 0, 0);
    endtask

    task automatic test_stall();
        int pulses;
        logic [8:0] exp_w;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 10'b10_0_00_0110_0, 1, 1, 0, 0, 0);
            if (ps_mul_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL stall_blocks got pulses=%0d exp=0", pulses);
        end
        step(1, 10'b10_0_00_0110_0, 1, 0, 0, 0, 0);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if (ps_mul_en !== 1'b1 || {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== exp_w) begin
            failures++;
            $display("FAIL stall_release got en=%b f=%h exp en=1 f=%h", ps_mul_en,
                     {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts}, exp_w);
        end
        if (ps_mul_en === 1'b1) pulses++;
        for (int i = 0; i < 3; i++) begin
            idle(0, 0, 0);
            if (ps_mul_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL stall_pulse_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_flags();
        do_reset();
        // op1: overflow with sign
        step(1, 10'b01_0_00_0000_0, 1, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 1, 1);
        checks++;
        if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== {3'b111, 8'd1}) begin
            failures++;
            $display("FAIL flags_op1 got mv=%b mn=%b stky=%b cnt=%0d exp 1 1 1 1", astat_mv, astat_mn, stky_mvs, ovf_cnt);
        end
        // op2: no overflow, sticky holds
        step(1, 10'b10_1_00_0010_0, 1, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        checks++;
        if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== {3'b001, 8'd1}) begin
            failures++;
            $display("FAIL flags_op2 got mv=%b mn=%b stky=%b cnt=%0d exp 0 0 1 1", astat_mv, astat_mn, stky_mvs, ovf_cnt);
        end
        // op3: overflow coincides with clear
        step(1, 10'b11_0_00_1111_0, 1, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(1, 1, 0);
        checks++;
        if ({astat_mv, stky_mvs, ovf_cnt} !== {2'b11, 8'd1}) begin
            failures++;
            $display("FAIL flags_op3_clr got mv=%b stky=%b cnt=%0d exp 1 1 1", astat_mv, stky_mvs, ovf_cnt);
        end
        idle(1, 0, 0);
        checks++;
        if ({astat_mv, stky_mvs, ovf_cnt} !== {2'b10, 8'd0}) begin
            failures++;
            $display("FAIL flags_clr_only got mv=%b stky=%b cnt=%0d exp 1 0 0", astat_mv, stky_mvs, ovf_cnt);
        end
        idle(0, 1, 0);
        idle(0, 0, 1);
        checks++;
        if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== {3'b100, 8'd0}) begin
            failures++;
            $display("FAIL flags_no_exe got mv=%b mn=%b stky=%b cnt=%0d exp 1 0 0 0", astat_mv, astat_mn, stky_mvs, ovf_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] cls, sc, dlo;
        logic       ot, mn;
        logic [9:0] opc;
        logic [8:0] exp_w;
        int         issued;
        do_reset();
        issued = 0;
        for (int i = 0; i < 265; i++) begin
            if (i < 260) begin
                cls = 2'($urandom_range(0, 3));
                sc  = (cls == 2'b00) ? 2'($urandom_range(0, 3)) : 2'b00;
                ot  = (cls == 2'b00 && sc == 2'b11) ? 1'b1 : 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       dlo = 2'b00;
                    1:       dlo = 2'b10;
                    default: dlo = 2'b11;
                endcase
                opc = {cls, ot, sc, 2'($urandom_range(0, 3)), dlo, 1'b0};
                mn  = 1'($urandom_range(0, 1));
                step(1, opc, 1, 0, 0, 1, mn);
            end else begin
                idle(0, 1, 1'($urandom_range(0, 1)));
            end
            if (ps_mul_en === 1'b1) issued++;
            checks++;
            if (ps_mul_en !== m_e1 || illegal_opc !== 1'b0) begin
                failures++;
                $display("FAIL b2b_en[%0d] got en=%b ill=%b exp en=%b ill=0", i, ps_mul_en, illegal_opc, m_e1);
            end
            if (m_e1) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                checks++;
                if ({ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== exp_w) begin
                    failures++;
                    $display("FAIL b2b_fields[%0d] got=%h exp=%h", i, {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts}, exp_w);
                end
            end
            checks++;
            if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== {m_mv, m_mn, m_stky, m_cnt}) begin
                failures++;
                $display("FAIL b2b_flags[%0d] got=%b_%b_%b_%h exp=%b_%b_%b_%h", i, astat_mv, astat_mn, stky_mvs, ovf_cnt,
                         m_mv, m_mn, m_stky, m_cnt);
            end
        end
        checks++;
        if (issued != 260 || ovf_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_saturate got issued=%0d cnt=%h exp issued=260 cnt=ff", issued, ovf_cnt);
        end
    endtask

    task automatic test_random();
        logic [9:0] opc;
        logic [8:0] exp_w;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            opc = 10'($urandom_range(0, 1023));
            step(1'($urandom_range(0, 3) != 0), opc, 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (ps_mul_en !== m_e1 || illegal_opc !== m_ill) begin
                failures++;
                $display("FAIL rnd_issue[%0d] got en=%b ill=%b exp en=%b ill=%b", i, ps_mul_en, illegal_opc, m_e1, m_ill);
            end
            if (m_e1) exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            checks++;
            if ({ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts} !== m_fld || (m_e1 && exp_w !== m_fld)) begin
                failures++;
                $display("FAIL rnd_fields[%0d] got=%h exp=%h", i, {ps_mul_cls, ps_mul_otreg, ps_mul_sc, ps_mul_dtsts}, m_fld);
            end
            checks++;
            if ({astat_mv, astat_mn, stky_mvs, ovf_cnt} !== {m_mv, m_mn, m_stky, m_cnt}) begin
                failures++;
                $display("FAIL rnd_flags[%0d] got=%b_%b_%b_%h exp=%b_%b_%b_%h", i, astat_mv, astat_mn, stky_mvs, ovf_cnt,
                         m_mv, m_mn, m_stky, m_cnt);
            end
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        step(1, 10'b01_1_00_0000_0, 1, 0, 0, 0, 0);
        idle(0, 0, 0);
        // this cycle is the execute cycle of the op
        mul_ps_mv = 1;
        #2 reset = 1;
        #1;
        checks++;
        if ({ps_mul_en, astat_mv, stky_mvs, ovf_cnt} !== 11'h000) begin
            failures++;
            $display("FAIL reset_exec_async got en=%b mv=%b stky=%b cnt=%0d exp 0 0 0 0", ps_mul_en, astat_mv, stky_mvs, ovf_cnt);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        idle(0, 1, 1);
        idle(0, 1, 1);
        checks++;
        if ({ps_mul_en, astat_mv, astat_mn, stky_mvs, ovf_cnt} !== 12'h000) begin
            failures++;
            $display("FAIL reset_exec_after got en=%b mv=%b mn=%b stky=%b cnt=%0d exp 0 0 0 0 0", ps_mul_en, astat_mv,
                     astat_mn, stky_mvs, ovf_cnt);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_issue();
        test_illegal();
        test_stall();
        test_flags();
        test_back_to_back();
        test_random();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
